// File: rtl/mips32_prog_loader.sv
// Streams instruction words into MIPS32 instruction memory from address 0, holds the core in reset while loading and guarantees a trailing HALT.
// Optional feature: define PROG_LOADER_CKSUM_EN to build the additive checksum of accepted words (cksum is constant 0 otherwise).
module mips32_prog_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
    input  logic              clk1,
    input  logic              reset_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       cksum
);

    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FILL = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     wc_q, wc_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                hold_q, hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
        if (v == DEPTH) begin
            sat_inc = v;
        end else begin
            sat_inc = v + (ADDR_W+1)'(1);
        end
    endfunction

    assign s_ready = (state_q == S_LOAD);

    // Next-state, write-port and status decode
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wc_d    = wc_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    wc_d    = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                if (s_valid) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = s_data;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    wc_d    = sat_inc(wc_q);
                    if (s_last) begin
                        if (s_data == HALT_WORD) begin
                            state_d = S_DONE;
                        end else if (ptr_q != PTR_LAST) begin
                            state_d = S_FILL;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else if (ptr_q == PTR_LAST) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_FILL: begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = HALT_WORD;
                wc_d    = sat_inc(wc_q);
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Status flags follow the next state so they change together with it
        busy_d = (state_d == S_LOAD) || (state_d == S_FILL);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
        hold_d = (state_d != S_DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            wc_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wc_q    <= wc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_hold   = hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_ovf    = err_q;
    assign word_count = wc_q;

`ifdef PROG_LOADER_CKSUM_EN
    logic [31:0] cksum_q, cksum_d;
    logic        load_entry_s;
    logic        accept_s;

    assign load_entry_s = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    assign accept_s     = s_valid && (state_q == S_LOAD);

    // Checksum accumulator; the appended HALT never passes through here
    always_comb begin
        cksum_d = cksum_q;
        if (load_entry_s) begin
            cksum_d = 32'd0;
        end else if (accept_s) begin
            cksum_d = cksum_q + s_data;
        end else begin
            cksum_d = cksum_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            cksum_q <= 32'd0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign cksum = cksum_q;
`else
    assign cksum = 32'd0;
`endif

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: a default-depth instance and a 4-word instance share one stimulus stream.
module tb_mips32_prog_loader;

`ifdef PROG_LOADER_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk1 = 1'b0;
    logic        reset_n;
    logic        start;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;

    logic        b_ready, b_we, b_hold, b_busy, b_done, b_err;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata, b_cksum;
    logic [10:0] b_wc;

    logic        m_ready, m_we, m_hold, m_busy, m_done, m_err;
    logic [1:0]  m_addr;
    logic [31:0] m_wdata, m_cksum;
    logic [2:0]  m_wc;

    int total = 0;
    int bad   = 0;

    mips32_prog_loader #(.ADDR_W(10)) dut (
        .clk1(clk1), .reset_n(reset_n), .start(start), .s_valid(s_valid), .s_ready(b_ready),
        .s_data(s_data), .s_last(s_last), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .cpu_hold(b_hold), .busy(b_busy), .done(b_done), .err_ovf(b_err), .word_count(b_wc),
        .cksum(b_cksum)
    );

    mips32_prog_loader #(.ADDR_W(2)) dut_small (
        .clk1(clk1), .reset_n(reset_n), .start(start), .s_valid(s_valid), .s_ready(m_ready),
        .s_data(s_data), .s_last(s_last), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata),
        .cpu_hold(m_hold), .busy(m_busy), .done(m_done), .err_ovf(m_err), .word_count(m_wc),
        .cksum(m_cksum)
    );

    always #5 clk1 = ~clk1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 32'd0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    function automatic logic [31:0] ck(input logic [31:0] v);
        return CK_EN ? v : 32'd0;
    endfunction

    initial begin
        logic [31:0] d;
        int gaps;

        // Reset values
        do_reset();
        check_val("rst_ready", 64'(b_ready), 64'(1'b0));
        check_val("rst_we", 64'(b_we), 64'(1'b0));
        check_val("rst_addr", 64'(b_addr), 64'(10'd0));
        check_val("rst_wdata", 64'(b_wdata), 64'(32'd0));
        check_val("rst_hold", 64'(b_hold), 64'(1'b1));
        check_val("rst_busy", 64'(b_busy), 64'(1'b0));
        check_val("rst_done", 64'(b_done), 64'(1'b0));
        check_val("rst_err", 64'(b_err), 64'(1'b0));
        check_val("rst_wc", 64'(b_wc), 64'(11'd0));
        check_val("rst_ck", 64'(b_cksum), 64'(32'd0));

        // Program ending in HALT: no fill write
        pulse_start();
        check_val("t1_ready", 64'(b_ready), 64'(1'b1));
        check_val("t1_busy", 64'(b_busy), 64'(1'b1));
        send(32'h00221000, 1'b0);
        check_val("t1_a0", 64'({b_we, b_addr, b_wdata}), 64'({1'b1, 10'd0, 32'h00221000}));
        send(32'h04822801, 1'b0);
        check_val("t1_a1", 64'({b_we, b_addr, b_wdata}), 64'({1'b1, 10'd1, 32'h04822801}));
        send(32'h28C60001, 1'b0);
        check_val("t1_a2", 64'({b_we, b_addr, b_wdata}), 64'({1'b1, 10'd2, 32'h28C60001}));
        send(32'hFC000000, 1'b1);
        check_val("t1_a3", 64'({b_we, b_addr, b_wdata}), 64'({1'b1, 10'd3, 32'hFC000000}));
        check_val("t1_done", 64'({b_done, b_hold, b_busy}), 64'({1'b1, 1'b0, 1'b0}));
        check_val("t1_wc", 64'(b_wc), 64'(11'd4));
        check_val("t1_ck", 64'(b_cksum), 64'(ck(32'h296A3802)));
        tick();
        check_val("t1_nofill", 64'(b_we), 64'(1'b0));

        // Three words, last not HALT: fill appends HALT at address 3
        do_reset();
        pulse_start();
        send(32'h11111111, 1'b0);
        send(32'h22222222, 1'b0);
        send(32'hF0000001, 1'b1);
        check_val("t2_a2", 64'({b_we, b_addr, b_wdata}), 64'({1'b1, 10'd2, 32'hF0000001}));
        check_val("t2_fill_st", 64'({b_done, b_busy, b_ready, b_hold}), 64'({1'b0, 1'b1, 1'b0, 1'b1}));
        check_val("t2_wc3", 64'(b_wc), 64'(11'd3));
        tick();
        check_val("t2_halt", 64'({b_we, b_addr, b_wdata}), 64'({1'b1, 10'd3, 32'hFC000000}));
        check_val("t2_done", 64'({b_done, b_hold}), 64'({1'b1, 1'b0}));
        check_val("t2_wc4", 64'(b_wc), 64'(11'd4));
        check_val("t2_ck", 64'(b_cksum), 64'(ck(32'h23333334)));
        tick();
        check_val("t2_idle_we", 64'(b_we), 64'(1'b0));

        // Depth-4 instance overflow without s_last
        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send(32'hA0000000 + 32'(i), 1'b0);
        end
        check_val("t3_a3", 64'({m_we, m_addr, m_wdata}), 64'({1'b1, 2'd3, 32'hA0000003}));
        check_val("t3_err", 64'({m_err, m_ready, m_hold, m_busy}), 64'({1'b1, 1'b0, 1'b1, 1'b0}));
        check_val("t3_wc", 64'(m_wc), 64'(3'd4));
        s_valid = 1'b1;
        s_data  = 32'hA0000004;
        tick();
        s_valid = 1'b0;
        check_val("t3_5th_rej", 64'({m_we, m_wc}), 64'({1'b0, 3'd4}));
        pulse_start();
        check_val("t3_restart", 64'({m_err, m_ready, m_wc}), 64'({1'b0, 1'b1, 3'd0}));
        send(32'hB0000000, 1'b0);
        check_val("t3_addr0", 64'({m_we, m_addr, m_wdata}), 64'({1'b1, 2'd0, 32'hB0000000}));

        // Depth-4 instance: last word at the final slot is not HALT
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            send(32'hC0000000 + 32'(i), 1'b0);
        end
        send(32'hC0000003, 1'b1);
        check_val("t4_a3", 64'({m_we, m_addr}), 64'({1'b1, 2'd3}));
        check_val("t4_err", 64'({m_err, m_done, m_hold}), 64'({1'b1, 1'b0, 1'b1}));
        tick();
        check_val("t4_nofill", 64'({m_we, m_wc}), 64'({1'b0, 3'd4}));

        // 20 words with random gaps and ignored start pulses
        do_reset();
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                tick();
                check_val("t5_gap_we", 64'(b_we), 64'(1'b0));
            end
            if (i == 6 || i == 13) begin
                pulse_start();
                check_val("t5_start_ign", 64'({b_ready, b_we, b_wc}), 64'({1'b1, 1'b0, 11'(i)}));
            end
            d = {16'hC0DE, 16'(i)};
            send(d, (i == 19) ? 1'b1 : 1'b0);
            check_val("t5_wr", 64'({b_we, b_addr, b_wdata}), 64'({1'b1, 10'(i), d}));
        end
        check_val("t5_wc", 64'(b_wc), 64'(11'd20));
        tick();
        check_val("t5_halt", 64'({b_we, b_addr, b_wdata}), 64'({1'b1, 10'd20, 32'hFC000000}));
        check_val("t5_done", 64'({b_done, b_wc}), 64'({1'b1, 11'd21}));

        // Asynchronous reset in the middle of a load
        do_reset();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            send(32'hD0000000 + 32'(i), 1'b0);
        end
        check_val("t6_pre", 64'({b_we, b_addr, b_wc}), 64'({1'b1, 10'd4, 11'd5}));
        #2;
        reset_n = 1'b0;
        #1;
        check_val("t6_rst_ctl", 64'({b_ready, b_we, b_hold, b_busy, b_done, b_err}),
                  64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        check_val("t6_rst_dat", 64'({b_addr, b_wdata, b_wc}), 64'({10'd0, 32'd0, 11'd0}));
        check_val("t6_rst_ck", 64'(b_cksum), 64'(32'd0));
        tick();
        reset_n = 1'b1;
        tick();
        pulse_start();
        send(32'hE0000000, 1'b0);
        check_val("t6_fresh", 64'({b_we, b_addr, b_wdata, b_wc}), 64'({1'b1, 10'd0, 32'hE0000000, 11'd1}));
        check_val("t6_ck", 64'(b_cksum), 64'(ck(32'hE0000000)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips32_prog_loader.md
# mips32_prog_loader

Program loader for the MIPS32 core. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive instruction-memory addresses starting at 0. While loading, it holds the core in reset, and it releases the core once the program is complete. It guarantees the loaded image ends in a HALT word, and it flags overflow if the stream exceeds memory depth.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory address width; memory depth = 2**ADDR_W words
- HALT_WORD, 32'hFC000000, HALT encoding (opcode 6'b111111, remaining bits zero)

Ports:
- clk1  in  1  sole clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse: begin a new load
- s_valid  in  1  stream word valid
- s_ready  out  1  loader can accept a word
- s_data  in  32  instruction word
- s_last  in  1  marks the final word of the program; qualified by s_valid
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  write data
- cpu_hold  out  1  high = keep MIPS32 in reset
- busy  out  1  load in progress
- done  out  1  program loaded, core released
- err_ovf  out  1  stream exceeded memory depth
- word_count  out  ADDR_W+1  words written, including any appended HALT
- cksum  out  32  additive checksum of accepted words

## Operation
- States: IDLE, LOAD, FILL, DONE, ERR.
- IDLE: entered on reset.
  - s_ready=0, cpu_hold=1.
  - start -> LOAD.
- LOAD:
  - On entry: write pointer=0, word_count=0, cksum=0, err_ovf=0.
  - s_ready=1, busy=1.
  - Each accepted word (s_valid&s_ready) is written at the pointer, and the pointer is incremented.
  - Accepted word with s_last=1:
    - If s_data==HALT_WORD -> DONE.
    - Else if the pointer after increment is < depth -> FILL.
    - Else -> ERR.
  - Accepted word with s_last=0 at pointer=depth-1 -> ERR. The word is still written.
- FILL:
  - Writes HALT_WORD at the pointer for one cycle; word_count increments.
  - s_ready=0.
  - Then -> DONE.
- DONE:
  - cpu_hold=0, done=1, busy=0, s_ready=0.
  - start -> LOAD; cpu_hold reasserts in the same cycle LOAD is entered.
- ERR:
  - err_ovf=1, cpu_hold=1, s_ready=0.
  - start -> LOAD, which clears err_ovf.
- start during LOAD or FILL is ignored.
- Words offered in IDLE, DONE or ERR are not accepted.
- Arithmetic:
  - word_count saturates at 2**ADDR_W.
  - cksum is sum mod 2**32 of accepted s_data only; the appended HALT is excluded.

## Timing
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, done=0, err_ovf=0, word_count=0, cksum=0; state IDLE.
- All outputs are registered except s_ready, which is decoded from state.
- start at cycle N -> LOAD at N+1; s_ready=1 at N+1.
- Handshake at cycle N -> mem_we=1 with that address/data at N+1; word_count and cksum update at N+1.
- Back-to-back acceptance: one word per cycle, no bubbles.
- Last word accepted at N, no FILL needed -> done=1 and cpu_hold=0 at N+1.
- With FILL: FILL state at N+1, HALT write strobe at N+2, done at N+2.
- s_valid may drop at any time in LOAD; the loader waits indefinitely.
- Asynchronous reset mid-load: immediately returns to IDLE with cpu_hold=1. A partially written memory is left as is.

## Configuration
- PROG_LOADER_CKSUM_EN defined: cksum accumulates as described above.
- PROG_LOADER_CKSUM_EN undefined: the accumulator is not built and cksum is constant 0. All other behaviour is unchanged.

## Test plan
- Reset, pulse start, stream 32'h00221000, 32'h04822801, 32'h28C60001, 32'hFC000000 (last): four writes at addresses 0-3, word_count=4, done=1 and cpu_hold=0 one cycle after the last accept, no FILL.
- Stream 3 words, last word not HALT: HALT_WORD written at address 3, word_count=4, done at accept+2, cksum = sum of the 3 words (0 if macro undefined).
- ADDR_W=2, stream 5 words without s_last: 4 writes, err_ovf=1 after the 4th accept, s_ready=0, cpu_hold=1; start clears err_ovf and restarts at address 0.
- ADDR_W=2, 4 words with the last non-HALT: ERR with no FILL write; err_ovf=1.
- Random s_valid gaps (≈50%) over 20 words: write addresses are contiguous 0-19 with data in order; start pulses during LOAD are ignored.
- reset_n low mid-stream after 5 words: all outputs return to reset values immediately; a fresh start loads from address 0.
